// File: rtl/fp_multiplier_pipe_if.sv
// Operand/result bundle for fp_multiplier_pipe: the requester drives start/A/B,
// and the multiplier returns ready, a one-cycle valid, the result word and its status flags.
interface fp_multiplier_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ready;
  logic         valid;
  logic [W-1:0] Out;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (
    output start, A, B,
    input  ready, valid, Out, overflow, underflow, invalid
  );

  modport slave (
    input  start, A, B,
    output ready, valid, Out, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_multiplier_pipe.sv
// Iterative shift-add FP multiplier: MAN_W+5 cycles start->valid, accepts work only while ready (IDLE).
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_multiplier_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                 clk,
  input logic                 reset,
  fp_multiplier_pipe_if.slave bus
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 1;
  localparam int P_W   = 2 * N;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(N);

  localparam logic [EXP_W-1:0]        EMAX     = '1;
  localparam logic signed [E_W-1:0]   BIAS     = E_W'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [E_W-1:0]   EMAX_S   = E_W'(2 ** EXP_W - 1);
  localparam logic signed [E_W-1:0]   E_ONE    = E_W'(1);
  localparam logic signed [E_W-1:0]   E_ZERO   = '0;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(N - 1);
  localparam logic [W-1:0]            QNAN     = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic                    sign_q, sign_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic [N-1:0]            ma_q, ma_d, mb_q, mb_d;
  logic [P_W-1:0]          p_q, p_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MAN_W-1:0]        frac_q, frac_d;
  logic                    sp_nan_q, sp_nan_d, sp_inv_q, sp_inv_d;
  logic                    sp_inf_q, sp_inf_d, sp_zero_q, sp_zero_d;
  logic [W-1:0]            out_q, out_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
  logic                    valid_q, valid_d, ready_q, ready_d;
`ifdef FP_MULT_RNE_EN
  logic                    g_q, g_d, s_q, s_d;
`endif

  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [P_W-1:0]          addend;
  logic                    round_inc;
  logic [MAN_W:0]          fsum;
  logic signed [E_W-1:0]   e_fin;
  logic [W-1:0]            res;
  logic                    res_ovf, res_unf, res_inv;

  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  // Denormals have exp=0 and are deliberately treated as zero.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);

  assign addend = mb_q[0] ? ({{N{1'b0}}, ma_q} << cnt_q) : '0;

`ifdef FP_MULT_RNE_EN
  assign round_inc = g_q & (s_q | frac_q[0]);
`else
  assign round_inc = 1'b0;
`endif

  // Carry out of the fraction means the mantissa rolled over to 2.0: fraction is already 0, bump E.
  assign fsum  = {1'b0, frac_q} + {{MAN_W{1'b0}}, round_inc};
  assign e_fin = e_q + $signed({{(E_W-1){1'b0}}, fsum[MAN_W]});

  always_comb begin
    res     = {sign_q, e_fin[EXP_W-1:0], fsum[MAN_W-1:0]};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inv = 1'b0;
    if (sp_nan_q) begin
      res = QNAN;
    end else if (sp_inv_q) begin
      res     = QNAN;
      res_inv = 1'b1;
    end else if (sp_inf_q) begin
      res = {sign_q, EMAX, {MAN_W{1'b0}}};
    end else if (sp_zero_q) begin
      res = {sign_q, {(W-1){1'b0}}};
    end else if (e_fin >= EMAX_S) begin
      res     = {sign_q, EMAX, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (e_fin <= E_ZERO) begin
      res     = {sign_q, {(W-1){1'b0}}};
      res_unf = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    e_d       = e_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    frac_d    = frac_q;
    sp_nan_d  = sp_nan_q;
    sp_inv_d  = sp_inv_q;
    sp_inf_d  = sp_inf_q;
    sp_zero_d = sp_zero_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inv_d     = inv_q;
    valid_d   = 1'b0;
`ifdef FP_MULT_RNE_EN
    g_d       = g_q;
    s_d       = s_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d    = a_q[W-1] ^ b_q[W-1];
        e_d       = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        ma_d      = {1'b1, fa};
        mb_d      = {1'b1, fb};
        p_d       = '0;
        cnt_d     = '0;
        sp_nan_d  = a_nan | b_nan;
        sp_inv_d  = (a_inf & b_zero) | (a_zero & b_inf);
        sp_inf_d  = a_inf | b_inf;
        sp_zero_d = a_zero | b_zero;
        state_d   = S_MUL;
      end
      S_MUL: begin
        p_d  = p_q + addend;
        mb_d = mb_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NORM: begin
        if (p_q[P_W-1]) begin
          frac_d = p_q[P_W-2 -: MAN_W];
          e_d    = e_q + E_ONE;
`ifdef FP_MULT_RNE_EN
          g_d    = p_q[N-1];
          s_d    = |p_q[N-2:0];
`endif
        end else begin
          frac_d = p_q[P_W-3 -: MAN_W];
`ifdef FP_MULT_RNE_EN
          g_d    = p_q[N-2];
          s_d    = |p_q[N-3:0];
`endif
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        out_d   = res;
        ovf_d   = res_ovf;
        unf_d   = res_unf;
        inv_d   = res_inv;
        valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      e_q       <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      sp_nan_q  <= 1'b0;
      sp_inv_q  <= 1'b0;
      sp_inf_q  <= 1'b0;
      sp_zero_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inv_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
`ifdef FP_MULT_RNE_EN
      g_q       <= 1'b0;
      s_q       <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      e_q       <= e_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      frac_q    <= frac_d;
      sp_nan_q  <= sp_nan_d;
      sp_inv_q  <= sp_inv_d;
      sp_inf_q  <= sp_inf_d;
      sp_zero_q <= sp_zero_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inv_q     <= inv_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
`ifdef FP_MULT_RNE_EN
      g_q       <= g_d;
      s_q       <= s_d;
`endif
    end
  end

  assign bus.ready     = ready_q;
  assign bus.valid     = valid_q;
  assign bus.Out       = out_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.invalid   = inv_q;
endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Bench for fp_multiplier_pipe: directed cases and random operands against an arithmetic reference,
// on a single-precision instance and a 5/10 half-style instance sharing clock and reset.
module tb_fp_multiplier_pipe;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_multiplier_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_s ();
  fp_multiplier_pipe_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

  fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));
  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product of the significands, then round and range-check. fl = {ovf, unf, inv}.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input int ew, input int mw,
                                  output logic [31:0] r, output logic [2:0] fl);
    longint emax, bias, fmask, ea, eb, fa, fb, e, prod, mant;
    int     shift;
    logic   sgn;
    emax  = (longint'(1) << ew) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    fmask = (longint'(1) << mw) - 1;
    ea    = (longint'(a) >> mw) & emax;
    eb    = (longint'(b) >> mw) & emax;
    fa    = longint'(a) & fmask;
    fb    = longint'(b) & fmask;
    sgn   = a[ew+mw] ^ b[ew+mw];
    fl    = 3'b000;
    if ((ea == emax && fa != 0) || (eb == emax && fb != 0)) begin
      r = 32'((emax << mw) | (longint'(1) << (mw - 1)));
    end else if ((ea == emax && eb == 0) || (ea == 0 && eb == emax)) begin
      r  = 32'((emax << mw) | (longint'(1) << (mw - 1)));
      fl = 3'b001;
    end else if (ea == emax || eb == emax) begin
      r = 32'((longint'(sgn) << (ew + mw)) | (emax << mw));
    end else if (ea == 0 || eb == 0) begin
      r = 32'(longint'(sgn) << (ew + mw));
    end else begin
      prod = (fa | (longint'(1) << mw)) * (fb | (longint'(1) << mw));
      e    = ea + eb - bias;
      if (prod >= (longint'(1) << (2 * mw + 1))) begin
        e++;
        shift = mw + 1;
      end else begin
        shift = mw;
      end
      mant = prod >> shift;
`ifdef FP_MULT_RNE_EN
      begin
        longint rem, half;
        rem  = prod & ((longint'(1) << shift) - 1);
        half = longint'(1) << (shift - 1);
        if (rem > half || (rem == half && (mant & 1) == 1)) mant++;
      end
`endif
      if (mant == (longint'(1) << (mw + 1))) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= emax) begin
        r  = 32'((longint'(sgn) << (ew + mw)) | (emax << mw));
        fl = 3'b100;
      end else if (e <= 0) begin
        r  = 32'(longint'(sgn) << (ew + mw));
        fl = 3'b010;
      end else begin
        r = 32'((longint'(sgn) << (ew + mw)) | (e << mw) | (mant & fmask));
      end
    end
  endfunction

  function automatic logic [31:0] gen_op(input int ew, input int mw);
    logic [31:0] e, f, s, emax, bias, fmask;
    int sel;
    emax  = (32'd1 << ew) - 1;
    bias  = (32'd1 << (ew - 1)) - 1;
    fmask = (32'd1 << mw) - 1;
    sel   = $urandom_range(0, 11);
    s     = 32'($urandom_range(0, 1));
    f     = $urandom & fmask;
    case (sel)
      0:       e = 0;
      1:       begin e = emax; if ($urandom_range(0, 1) == 0) f = 0; end
      2:       e = $urandom_range(1, emax - 1);
      3:       begin e = $urandom_range(bias - bias / 2, bias + bias / 2); f = fmask; end
      default: e = $urandom_range(bias - bias / 2, bias + bias / 2);
    endcase
    return (s << (ew + mw)) | (e << mw) | f;
  endfunction

  // Called at a falling edge; returns result, flags and the number of rising edges from start to valid.
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (half ? bus_h.ready : bus_s.ready) break;
      @(negedge clk);
    end
    if (half) begin
      bus_h.start = 1'b1; bus_h.A = a[15:0]; bus_h.B = b[15:0];
    end else begin
      bus_s.start = 1'b1; bus_s.A = a; bus_s.B = b;
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      bus_s.start = 1'b0;
      bus_h.start = 1'b0;
      if (half ? bus_h.valid : bus_s.valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("valid_timeout", 64'(got), 64'd1);
    if (half) begin
      r  = {16'h0, bus_h.Out};
      fl = {bus_h.overflow, bus_h.underflow, bus_h.invalid};
    end else begin
      r  = bus_s.Out;
      fl = {bus_s.overflow, bus_s.underflow, bus_s.invalid};
      check("ready_in_done", 64'(bus_s.ready), 64'd0);
      @(negedge clk);
      check("ready_after_done", 64'(bus_s.ready), 64'd1);
      check("valid_one_cycle", 64'(bus_s.valid), 64'd0);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [2:0]  fl;
  } vec_t;

  initial begin
    vec_t        dir [$];
    logic [31:0] r, er, got_out;
    logic [2:0]  fl, efl;
    int          lat, nv;

    reset       = 1'b1;
    bus_s.start = 1'b0; bus_s.A = '0; bus_s.B = '0;
    bus_h.start = 1'b0; bus_h.A = '0; bus_h.B = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus_s.ready), 64'd1);
    check("rst_valid", 64'(bus_s.valid), 64'd0);
    check("rst_out", 64'(bus_s.Out), 64'd0);
    check("rst_flags", 64'({bus_s.overflow, bus_s.underflow, bus_s.invalid}), 64'd0);
    check("rst_ready_h", 64'(bus_h.ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    dir.push_back('{32'h40a00000, 32'h40000000, 32'h41200000, 3'b000});
    dir.push_back('{32'hc0b00000, 32'h40300000, 32'hc1720000, 3'b000});
`ifdef FP_MULT_RNE_EN
    dir.push_back('{32'h3fc00000, 32'h3f800001, 32'h3fc00002, 3'b000});
`else
    dir.push_back('{32'h3fc00000, 32'h3f800001, 32'h3fc00001, 3'b000});
`endif
    dir.push_back('{32'h7f800000, 32'h00000000, 32'h7fc00000, 3'b001});
    dir.push_back('{32'h7f000000, 32'h7f000000, 32'h7f800000, 3'b100});
    dir.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 3'b010});
    dir.push_back('{32'hff800000, 32'h40000000, 32'hff800000, 3'b000});
    dir.push_back('{32'h7fc00001, 32'h00000000, 32'h7fc00000, 3'b000});
    foreach (dir[i]) begin
      run_op(1'b0, dir[i].a, dir[i].b, r, fl, lat);
      check($sformatf("dir%0d_out", i), 64'(r), 64'(dir[i].r));
      check($sformatf("dir%0d_flags", i), 64'(fl), 64'(dir[i].fl));
      check($sformatf("dir%0d_latency", i), 64'(lat), 64'd28);
    end

    // A start arriving mid-operation must be dropped.
    bus_s.start = 1'b1; bus_s.A = 32'h40a00000; bus_s.B = 32'h40000000;
    nv = 0; got_out = '0; lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      bus_s.start = (i == 10);
      if (i == 10) begin
        bus_s.A = 32'h3f800000; bus_s.B = 32'h3f800000;
      end
      if (bus_s.valid) begin
        nv++;
        if (nv == 1) begin
          got_out = bus_s.Out;
          lat = i;
        end
      end
    end
    check("ignored_start_out", 64'(got_out), 64'h41200000);
    check("ignored_start_pulses", 64'(nv), 64'd1);
    check("ignored_start_latency", 64'(lat), 64'd28);

    // Reset mid-MUL after an overflowing result, so both Out and a flag are non-zero beforehand.
    run_op(1'b0, 32'h7f000000, 32'h7f000000, r, fl, lat);
    check("pre_reset_out", 64'(r), 64'h7f800000);
    bus_s.start = 1'b1; bus_s.A = 32'hc0b00000; bus_s.B = 32'h40300000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_s.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_ready", 64'(bus_s.ready), 64'd1);
    check("midrst_valid", 64'(bus_s.valid), 64'd0);
    check("midrst_out", 64'(bus_s.Out), 64'd0);
    check("midrst_flags", 64'({bus_s.overflow, bus_s.underflow, bus_s.invalid}), 64'd0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_s.valid) nv++;
    end
    check("midrst_no_valid", 64'(nv), 64'd0);
    run_op(1'b0, 32'h40a00000, 32'h40000000, r, fl, lat);
    check("post_rst_out", 64'(r), 64'h41200000);
    check("post_rst_flags", 64'(fl), 64'd0);

    // Narrow format.
    run_op(1'b1, 32'h4500, 32'h4000, r, fl, lat);
    check("h_5x2_out", 64'(r), 64'h4900);
    check("h_5x2_flags", 64'(fl), 64'd0);
    check("h_5x2_latency", 64'(lat), 64'd15);
    run_op(1'b1, 32'h7800, 32'h7800, r, fl, lat);
    check("h_ovf_out", 64'(r), 64'h7c00);
    check("h_ovf_flags", 64'(fl), 64'b100);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      a = gen_op(8, 23);
      b = gen_op(8, 23);
      ref_mul(a, b, 8, 23, er, efl);
      run_op(1'b0, a, b, r, fl, lat);
      check($sformatf("rnd_s %h*%h out", a, b), 64'(r), 64'(er));
      check($sformatf("rnd_s %h*%h flags", a, b), 64'(fl), 64'(efl));
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = gen_op(5, 10);
      b = gen_op(5, 10);
      ref_mul(a, b, 5, 10, er, efl);
      run_op(1'b1, a, b, r, fl, lat);
      check($sformatf("rnd_h %h*%h out", a, b), 64'(r), 64'(er));
      check($sformatf("rnd_h %h*%h flags", a, b), 64'(fl), 64'(efl));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
